// File: rtl/input_controller_pkg.sv
// Shared definitions for the IN-instruction input controller: bus widths,
// FSM state encoding and the switch-to-word extension helper.
package input_controller_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    ACK        = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] extend_switches(input logic [SW_W-1:0] sw,
                                                        input bit              sign_ext);
    if (sign_ext)
      return {{(DATA_W-SW_W){sw[SW_W-1]}}, sw};
    return {{(DATA_W-SW_W){1'b0}}, sw};
  endfunction

endpackage

// File: rtl/input_controller_if.sv
// Processor/board side signals of the input controller; the master side is the
// processor plus board, the slave side is the controller itself.
interface input_controller_if;
  import input_controller_pkg::*;

  logic              InReq;
  logic [SW_W-1:0]   Switches;
  logic              Enter;
  logic [DATA_W-1:0] DataIO;
  logic              Halt;
  logic              InAck;

  modport master (output InReq, output Switches, output Enter,
                  input  DataIO, input Halt, input InAck);
  modport slave  (input  InReq, input Switches, input Enter,
                  output DataIO, output Halt, output InAck);
endinterface

// File: rtl/input_controller_debouncer.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter that
// outputs the filtered pushbutton level.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Metastability guard: the raw button is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Any sample agreeing with the filtered level restarts the run; the level
  // flips on the last of DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (sync_p1 == filtered) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      filtered <= sync_p1;
      cnt      <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/input_controller.sv
// Stalls the processor on an IN instruction until the user presses Enter, then
// captures the switches into DataIO and acknowledges with a one-cycle pulse.
module input_controller
  import input_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit SIGN_EXT        = 1'b1
) (
  input  logic               Clock,
  input  logic               Reset,
  input_controller_if.slave  io
);

  state_t            state;
  state_t            state_next;
  logic              enter_filt;
  logic              enter_filt_d;
  logic              press;
  logic              capture;
  logic [DATA_W-1:0] data_q;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (Clock),
    .rst_n    (Reset),
    .raw      (io.Enter),
    .filtered (enter_filt)
  );

  // Rising-edge detect: a held button yields exactly one press, so it can
  // never satisfy a second IN without being released first.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      enter_filt_d <= 1'b0;
    else
      enter_filt_d <= enter_filt;
  end

  assign press = enter_filt & ~enter_filt_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // An InReq drop in WAIT_PRESS takes priority over a simultaneous press.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.InReq)
          state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!io.InReq) begin
          state_next = IDLE;
        end else if (press) begin
          state_next = ACK;
          capture    = 1'b1;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      data_q <= '0;
    else if (capture)
      data_q <= extend_switches(io.Switches, SIGN_EXT);
  end

  assign io.DataIO = data_q;
  assign io.Halt   = (state == WAIT_PRESS);
  assign io.InAck  = (state == ACK);

endmodule
